// File: rtl/i2c_temp_sequencer_pkg.sv
// Shared command encodings, sensor defaults and address-byte helper for the temperature poller.
// Latency: none, declarations only.
// Backpressure: not applicable.
package i2c_temp_sequencer_pkg;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_START     = 3'd1,
        CMD_WRITE     = 3'd2,
        CMD_READ_ACK  = 3'd3,
        CMD_READ_NACK = 3'd4,
        CMD_STOP      = 3'd5
    } cmd_e;

    localparam logic [6:0] DEV_ADDR_DEF = 7'h4B;
    localparam logic [7:0] REG_PTR_DEF  = 8'h00;

    // I2C address byte: 7-bit address followed by the R/W bit (1 = read).
    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rd);
        return {addr, rd};
    endfunction

endpackage

// File: rtl/i2c_temp_sequencer_if.sv
// Command/response link between the poll sequencer and the byte-level I2C master engine.
// Latency: wires only.
// Backpressure: cmd_valid/cmd_ready on commands; responses are 1-cycle pulses, never stalled.
interface i2c_temp_sequencer_if;
    import i2c_temp_sequencer_pkg::*;

    logic       cmd_valid;
    cmd_e       cmd;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_nack
    );

endinterface

// File: rtl/i2c_temp_sequencer_poll_timer.sv
// Free-running poll interval counter; tick is high for the single cycle at count POLL_CYCLES-1.
// Latency: first tick POLL_CYCLES cycles after en rises.
// Backpressure: none; ticks are not held for a busy consumer.
module poll_timer #(
    parameter int unsigned POLL_CYCLES = 100_000_000
) (
    input  logic CLK100MHZ,
    input  logic btnC,
    input  logic en,
    output logic tick
);

    localparam int unsigned  CW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Dropping en parks the count at zero so a re-enable always waits a full interval.
    always_ff @(posedge CLK100MHZ) begin
        if (btnC) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_temp_sequencer.sv
// Polls the I2C temperature sensor each tick: ptr write, repeated start, 2-byte read; retries on NACK.
// Latency: one command in flight; temp_valid one cycle after the final STOP completes.
// Backpressure: each command is held stable until cmd_ready; the FSM then waits for rsp_valid.
module i2c_temp_sequencer
    import i2c_temp_sequencer_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEF,
    parameter logic [7:0]  REG_PTR     = REG_PTR_DEF,
    parameter int unsigned POLL_CYCLES = 100_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                  CLK100MHZ,
    input  logic                  btnC,
    input  logic                  btnR,
    i2c_temp_sequencer_if.master  bus,
    output logic [15:0]           temp,
    output logic                  temp_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned   RW        = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_ADDR_W   = 4'd2;
    localparam logic [3:0] S_PTR      = 4'd3;
    localparam logic [3:0] S_RSTART   = 4'd4;
    localparam logic [3:0] S_ADDR_R   = 4'd5;
    localparam logic [3:0] S_RD_MSB   = 4'd6;
    localparam logic [3:0] S_RD_LSB   = 4'd7;
    localparam logic [3:0] S_STOP     = 4'd8;
    localparam logic [3:0] S_UPDATE   = 4'd9;
    localparam logic [3:0] S_ERR_STOP = 4'd10;

    logic [3:0]    state;
    logic          pending;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nxt;
    logic [7:0]    msb_q;
    logic [7:0]    lsb_q;
    logic          tick;
    logic          cmd_state;
    cmd_e          cmd_sel;
    logic [7:0]    data_sel;

    poll_timer #(
        .POLL_CYCLES (POLL_CYCLES)
    ) u_poll_timer (
        .CLK100MHZ (CLK100MHZ),
        .btnC      (btnC),
        .en        (btnR),
        .tick      (tick)
    );

    always_comb begin
        cmd_state = 1'b1;
        cmd_sel   = CMD_NONE;
        data_sel  = 8'h00;
        case (state)
            S_START, S_RSTART:   cmd_sel = CMD_START;
            S_ADDR_W: begin
                cmd_sel  = CMD_WRITE;
                data_sel = addr_byte(DEV_ADDR, 1'b0);
            end
            S_PTR: begin
                cmd_sel  = CMD_WRITE;
                data_sel = REG_PTR;
            end
            S_ADDR_R: begin
                cmd_sel  = CMD_WRITE;
                data_sel = addr_byte(DEV_ADDR, 1'b1);
            end
            S_RD_MSB:            cmd_sel = CMD_READ_ACK;
            S_RD_LSB:            cmd_sel = CMD_READ_NACK;
            S_STOP, S_ERR_STOP:  cmd_sel = CMD_STOP;
            default:             cmd_state = 1'b0;
        endcase
    end

    // cmd/cmd_data follow the state only, so they cannot move while a request is stalled.
    assign bus.cmd_valid = cmd_state && !pending;
    assign bus.cmd       = cmd_sel;
    assign bus.cmd_data  = data_sel;
    assign retry_nxt     = retry_cnt + RW'(1);

    always_ff @(posedge CLK100MHZ) begin
        if (btnC) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            retry_cnt  <= '0;
            msb_q      <= 8'h00;
            lsb_q      <= 8'h00;
            temp       <= 16'h0000;
            temp_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (tick) begin
                    state <= S_START;
                    busy  <= 1'b1;
                end
            end else if (state == S_UPDATE) begin
                temp       <= {msb_q, lsb_q};
                temp_valid <= 1'b1;
                err        <= 1'b0;
                retry_cnt  <= '0;
                state      <= S_IDLE;
            end else if (!cmd_state) begin
                state   <= S_IDLE;
                pending <= 1'b0;
                busy    <= 1'b0;
            end else if (!pending) begin
                if (bus.cmd_ready) begin
                    pending <= 1'b1;
                end
            end else if (bus.rsp_valid) begin
                pending <= 1'b0;
                case (state)
                    S_START:  state <= S_ADDR_W;
                    S_ADDR_W: state <= bus.rsp_nack ? S_ERR_STOP : S_PTR;
                    S_PTR:    state <= bus.rsp_nack ? S_ERR_STOP : S_RSTART;
                    S_RSTART: state <= S_ADDR_R;
                    S_ADDR_R: state <= bus.rsp_nack ? S_ERR_STOP : S_RD_MSB;
                    S_RD_MSB: begin
                        msb_q <= bus.rsp_data;
                        state <= S_RD_LSB;
                    end
                    S_RD_LSB: begin
                        lsb_q <= bus.rsp_data;
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        busy  <= 1'b0;
                        state <= S_UPDATE;
                    end
                    S_ERR_STOP: begin
                        // busy stays up across retries; only the give-up path ends the poll here.
                        if (retry_nxt <= RETRY_MAX) begin
                            retry_cnt <= retry_nxt;
                            state     <= S_START;
                        end else begin
                            err       <= 1'b1;
                            retry_cnt <= '0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
